// File: rtl/subbytes_state_engine.sv
// Byte-serial AES SubBytes over a 128-bit state with Hamming(12,8) parity prediction and checking.
// Latency: out_valid rises 17 cycles after the acceptance edge; one byte is issued per cycle.
// Backpressure: in_ready only in IDLE; DONE holds every output stable until out_ready.
module subbytes_state_engine (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         fault_en,
    input  logic [3:0]   fault_byte,
    input  logic [11:0]  fault_mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         err_flag,
    output logic [3:0]   err_byte,
    output logic [3:0]   err_syndrome,
    output logic [4:0]   err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entry 0x00 is the most significant byte, so byte x sits at bit offset 8*(255-x).
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    // Check bits occupy codeword positions 1,2,4,8 and d0..d7 positions 3,5,6,7,9,10,11,12,
    // so any single flipped bit produces its own codeword position as the syndrome.
    function automatic logic [3:0] f_hamming_par(input logic [7:0] d);
        logic [3:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return p;
    endfunction

    state_t        r_state;
    state_t        w_next;
    logic [127:0]  r_in_state;
    logic          r_fault_en;
    logic [3:0]    r_fault_byte;
    logic [11:0]   r_fault_mask;
    logic [4:0]    r_cnt;
    logic [11:0]   r_stg;
    logic [3:0]    r_stg_idx;
    logic          r_stg_vld;
    logic [127:0]  r_out_state;
    logic          r_err_flag;
    logic [3:0]    r_err_byte;
    logic [3:0]    r_err_syn;
    logic [4:0]    r_err_cnt;

    logic [7:0]    w_byte;
    logic [7:0]    w_sbox;
    logic [3:0]    w_pred;
    logic [11:0]   w_word;
    logic [3:0]    w_syn;
    logic          w_last;

    assign w_byte = r_in_state[{r_cnt[3:0], 3'b000} +: 8];
    assign w_sbox = f_sbox(w_byte);
    assign w_pred = f_hamming_par(f_sbox(w_byte));
    assign w_word = {w_sbox, w_pred}
                  ^ ((r_fault_en && (r_fault_byte == r_cnt[3:0])) ? r_fault_mask : 12'h000);
    assign w_syn  = f_hamming_par(r_stg[11:4]) ^ r_stg[3:0];
    assign w_last = r_stg_vld && (r_stg_idx == 4'd15);

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign out_state    = r_out_state;
    assign err_flag     = r_err_flag;
    assign err_byte     = r_err_byte;
    assign err_syndrome = r_err_syn;
    assign err_count    = r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_state   <= '0;
            r_fault_en   <= 1'b0;
            r_fault_byte <= '0;
            r_fault_mask <= '0;
            r_cnt        <= '0;
            r_stg        <= '0;
            r_stg_idx    <= '0;
            r_stg_vld    <= 1'b0;
            r_out_state  <= '0;
            r_err_flag   <= 1'b0;
            r_err_byte   <= '0;
            r_err_syn    <= '0;
            r_err_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_state   <= in_state;
                        r_fault_en   <= fault_en;
                        r_fault_byte <= fault_byte;
                        r_fault_mask <= fault_mask;
                        r_cnt        <= '0;
                        r_stg_vld    <= 1'b0;
                        r_err_flag   <= 1'b0;
                        r_err_byte   <= '0;
                        r_err_syn    <= '0;
                        r_err_cnt    <= '0;
                    end
                end
                RUN: begin
                    // Issue stops once the counter passes byte 15; the stage then drains.
                    if (!r_cnt[4]) begin
                        r_stg     <= w_word;
                        r_stg_idx <= r_cnt[3:0];
                        r_stg_vld <= 1'b1;
                        r_cnt     <= r_cnt + 5'd1;
                    end else begin
                        r_stg_vld <= 1'b0;
                    end
                    if (r_stg_vld) begin
                        r_out_state[{r_stg_idx, 3'b000} +: 8] <= r_stg[11:4];
                        if (w_syn != 4'd0) begin
                            r_err_cnt <= r_err_cnt + 5'd1;
                            if (!r_err_flag) begin
                                r_err_flag <= 1'b1;
                                r_err_byte <= r_stg_idx;
                                r_err_syn  <= w_syn;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_state_engine.sv
// Scoreboard bench for subbytes_state_engine: reference S-box rows and positional syndrome model.
module tb_subbytes_state_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         fault_en;
    logic [3:0]   fault_byte;
    logic [11:0]  fault_mask;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         err_flag;
    logic [3:0]   err_byte;
    logic [3:0]   err_syndrome;
    logic [4:0]   err_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] st;
        logic         flag;
        logic [3:0]   eb;
        logic [3:0]   syn;
        logic [4:0]   cnt;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [127:0] SB_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always #5 clk = ~clk;

    subbytes_state_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .fault_en(fault_en), .fault_byte(fault_byte), .fault_mask(fault_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .err_flag(err_flag), .err_byte(err_byte), .err_syndrome(err_syndrome),
        .err_count(err_count)
    );

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [127:0] row;
        int col;
        row = SB_ROW[x[7:4]];
        col = int'(x[3:0]);
        return row[(15 - col) * 8 +: 8];
    endfunction

    // Syndrome of an error pattern = XOR of the codeword positions it flips.
    function automatic logic [3:0] ref_syn(input logic [11:0] m);
        logic [3:0] s;
        s = m[3:0];
        if (m[4])  s = s ^ 4'd3;
        if (m[5])  s = s ^ 4'd5;
        if (m[6])  s = s ^ 4'd6;
        if (m[7])  s = s ^ 4'd7;
        if (m[8])  s = s ^ 4'd9;
        if (m[9])  s = s ^ 4'd10;
        if (m[10]) s = s ^ 4'd11;
        if (m[11]) s = s ^ 4'd12;
        return s;
    endfunction

    function automatic exp_t ref_model(input logic [127:0] st, input logic fen,
                                       input logic [3:0] fb, input logic [11:0] fm);
        exp_t e;
        logic [7:0] b;
        logic [3:0] s;
        e.st = '0; e.flag = 1'b0; e.eb = '0; e.syn = '0; e.cnt = '0;
        for (int k = 0; k < 16; k++) begin
            b = ref_sbox(st[8*k +: 8]);
            if (fen && (int'(fb) == k)) begin
                b = b ^ fm[11:4];
                s = ref_syn(fm);
                if (s != 4'd0) begin
                    e.cnt  = e.cnt + 5'd1;
                    e.flag = 1'b1;
                    e.eb   = fb;
                    e.syn  = s;
                end
            end
            e.st[8*k +: 8] = b;
        end
        return e;
    endfunction

    task automatic send(input logic [127:0] st, input logic fen,
                        input logic [3:0] fb, input logic [11:0] fm);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
        in_state = st; fault_en = fen; fault_byte = fb; fault_mask = fm;
        in_valid = 1'b1;
        sb_q.push_back(ref_model(st, fen, fb, fm));
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_state   = {$urandom, $urandom, $urandom, $urandom};
        fault_en   = 1'($urandom_range(0, 1));
        fault_byte = 4'($urandom_range(0, 15));
        fault_mask = 12'($urandom);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL accept_in_ready: got %b want 0", in_ready);
        end
    endtask

    task automatic wait_out(input string nm);
        int cyc;
        bit rdy_seen;
        cyc = 0;
        rdy_seen = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) rdy_seen = 1;
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        if (cyc != 17 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles (out_valid=%b) want 17", nm, cyc, out_valid);
        end
        n_vec++;
        if (rdy_seen) begin
            n_err++;
            $display("FAIL %s_busy_in_ready: in_ready seen 1 during run, want 0", nm);
        end
    endtask

    task automatic sb_compare(input string nm);
        exp_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_scoreboard: output with no expected entry", nm);
        end else begin
            e = sb_q.pop_front();
            if (out_state !== e.st) begin
                n_err++;
                $display("FAIL %s_state: got %h want %h", nm, out_state, e.st);
            end
            n_vec++;
            if (err_flag !== e.flag) begin
                n_err++;
                $display("FAIL %s_err_flag: got %b want %b", nm, err_flag, e.flag);
            end
            n_vec++;
            if (err_byte !== e.eb) begin
                n_err++;
                $display("FAIL %s_err_byte: got %0d want %0d", nm, err_byte, e.eb);
            end
            n_vec++;
            if (err_syndrome !== e.syn) begin
                n_err++;
                $display("FAIL %s_err_syndrome: got %h want %h", nm, err_syndrome, e.syn);
            end
            n_vec++;
            if (err_count !== e.cnt) begin
                n_err++;
                $display("FAIL %s_err_count: got %0d want %0d", nm, err_count, e.cnt);
            end
        end
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_handshake: got out_valid=%b in_ready=%b want 0/1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_state !== 128'h0 || err_flag !== 1'b0
            || err_byte !== 4'h0 || err_syndrome !== 4'h0 || err_count !== 5'h0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b vld=%b st=%h flag=%b byte=%h syn=%h cnt=%h want 1,0,0...",
                     in_ready, out_valid, out_state, err_flag, err_byte, err_syndrome, err_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_zero();
        send(128'h0, 1'b0, 4'd0, 12'h000);
        wait_out("zero");
        n_vec++;
        if (out_state !== {16{8'h63}}) begin
            n_err++;
            $display("FAIL zero_const: got %h want all 63", out_state);
        end
        sb_compare("zero");
        release_out("zero");
    endtask

    task automatic test_mixed();
        logic [127:0] st;
        st = '0;
        st[15:8]  = 8'h01;
        st[23:16] = 8'h53;
        send(st, 1'b0, 4'd0, 12'h000);
        wait_out("mixed");
        n_vec++;
        if (out_state[23:0] !== 24'hED7C63) begin
            n_err++;
            $display("FAIL mixed_bytes: got %h want ed7c63", out_state[23:0]);
        end
        sb_compare("mixed");
        release_out("mixed");
    endtask

    task automatic test_data_fault();
        send(128'h0, 1'b1, 4'd5, 12'h010);
        wait_out("dfault");
        n_vec++;
        if (out_state[47:40] !== 8'h62 || err_syndrome == 4'd0) begin
            n_err++;
            $display("FAIL dfault_byte5: got byte %h syn %h want 62 and nonzero", out_state[47:40], err_syndrome);
        end
        sb_compare("dfault");
        release_out("dfault");
    endtask

    task automatic test_parity_faults();
        send(128'h0, 1'b1, 4'd0, 12'h001);
        wait_out("pfault");
        n_vec++;
        if (out_state !== {16{8'h63}} || err_flag !== 1'b1) begin
            n_err++;
            $display("FAIL pfault_data: got %h flag %b want all 63 flag 1", out_state, err_flag);
        end
        sb_compare("pfault");
        release_out("pfault");
        send(128'h0, 1'b1, 4'd15, 12'h801);
        wait_out("dbl");
        n_vec++;
        if (out_state[127:120] !== 8'hE3 || err_byte !== 4'd15) begin
            n_err++;
            $display("FAIL dbl_byte15: got %h byte %0d want e3 15", out_state[127:120], err_byte);
        end
        sb_compare("dbl");
        release_out("dbl");
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd7, 12'h000);
        wait_out("zmask");
        sb_compare("zmask");
        release_out("zmask");
    endtask

    task automatic test_back_to_back();
        logic [127:0] snap_st;
        logic [11:0]  snap_err;
        logic [127:0] st2;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd9, 12'h0C4);
        wait_out("bp");
        snap_st  = out_state;
        snap_err = {err_byte, err_syndrome, err_flag, err_count[2:0]};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== snap_st || err_count[4:3] !== 2'b00 && 1'b0
                || {err_byte, err_syndrome, err_flag, err_count[2:0]} !== snap_err) begin
                n_err++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b st=%h want 1,0,%h", i, out_valid, in_ready, out_state, snap_st);
            end
        end
        sb_compare("bp");
        st2 = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_state  = st2;
        fault_en  = 1'b0;
        sb_q.push_back(ref_model(st2, 1'b0, 4'd0, 12'h000));
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_handshake_cycle: rdy=%b vld=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: in_ready=%b want 0", in_ready);
        end
        wait_out("b2b");
        sb_compare("b2b");
        release_out("b2b");
    endtask

    task automatic test_reset_mid_run();
        exp_t dropped;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 4'd2, 12'h100);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        dropped = sb_q.pop_back();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (out_valid !== 1'b0 || out_state !== 128'h0 || err_flag !== 1'b0 || err_count !== 5'd0
                || err_byte !== 4'd0 || err_syndrome !== 4'd0) begin
                n_err++;
                $display("FAIL rst_mid_%0d: vld=%b st=%h flag=%b cnt=%0d want all 0", i, out_valid, out_state, err_flag, err_count);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release: rdy=%b vld=%b want 1/0 (dropped cnt %0d)", in_ready, out_valid, dropped.cnt);
        end
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 4'd0, 12'h000);
        wait_out("post_rst");
        sb_compare("post_rst");
        release_out("post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 12'($urandom));
            wait_out("rand");
            sb_compare("rand");
            release_out("rand");
        end
    endtask

    initial begin
        in_valid = 1'b0; in_state = '0; fault_en = 1'b0; fault_byte = '0;
        fault_mask = '0; out_ready = 1'b0; rst_n = 1'b0;
        test_reset();
        test_all_zero();
        test_mixed();
        test_data_fault();
        test_parity_faults();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
